// File: rtl/vend_pkg.sv
// vend_pkg: shared encodings for the coin payout hopper controller.
//   state_t     - payout FSM states
//   coin_sel_t  - hopper denomination select (00=1, 01=2, 10=5, 11 unused)
//   VAL_*       - denomination values in currency units
//   coin_value  - maps a coin_sel code to its value
package vend_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_REQ,
    S_REL,
    S_DONE,
    S_SHORT,
    S_FAULT
  } state_t;

  typedef enum logic [1:0] {
    SEL_1 = 2'b00,
    SEL_2 = 2'b01,
    SEL_5 = 2'b10
  } coin_sel_t;

  localparam logic [3:0] VAL_1 = 4'd1;
  localparam logic [3:0] VAL_2 = 4'd2;
  localparam logic [3:0] VAL_5 = 4'd5;

  // The unused code 11 is worth nothing, so it can never move remaining.
  function automatic logic [3:0] coin_value(input logic [1:0] sel);
    case (sel)
      SEL_1:   coin_value = VAL_1;
      SEL_2:   coin_value = VAL_2;
      SEL_5:   coin_value = VAL_5;
      default: coin_value = '0;
    endcase
  endfunction

endpackage

// File: rtl/coin_pick.sv
// coin_pick: greedy denomination chooser (purely combinational).
//   remaining  in  amount still owed (caller handles remaining == 0)
//   n5/n2/n1   in  hopper inventory per denomination
//   sel        out chosen coin_sel code
//   valid      out a coin can be paid; low means the change cannot be made
module coin_pick
  import vend_pkg::*;
(
  input  logic [3:0] remaining,
  input  logic [3:0] n5,
  input  logic [3:0] n2,
  input  logic [3:0] n1,
  output logic [1:0] sel,
  output logic       valid
);

  always_comb begin
    sel   = SEL_1;
    valid = 1'b0;
    if ((remaining >= VAL_5) && (n5 != '0)) begin
      sel   = SEL_5;
      valid = 1'b1;
    end else if ((remaining >= VAL_2) && (n2 != '0)) begin
      sel   = SEL_2;
      valid = 1'b1;
    end else if (n1 != '0) begin
      sel   = SEL_1;
      valid = 1'b1;
    end
  end

endmodule

// File: rtl/coin_payout.sv
// coin_payout: pays out change one coin at a time through a hopper handshake.
//   clk_1ms    in  sole clock, rising edge
//   rst_n      in  asynchronous active-low reset
//   start      in  one-cycle strobe, latches amount when idle
//   amount     in  change to pay (0-15)
//   clr        in  clears the SHORT / FAULT conditions
//   coin_ack   in  hopper acknowledge (level)
//   coin_req   out request one coin of coin_sel
//   coin_sel   out 00=1, 01=2, 10=5 units
//   busy       out high whenever not idle
//   done       out one-cycle pulse at payout completion
//   short      out inventory cannot make the remaining change
//   fault      out hopper failed to acknowledge in time
//   remaining  out amount still owed
//   empty      out {5,2,1} inventory-zero flags
module coin_payout
  import vend_pkg::*;
#(
  parameter int unsigned N5_INIT     = 4,
  parameter int unsigned N2_INIT     = 6,
  parameter int unsigned N1_INIT     = 8,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       clk_1ms,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] amount,
  input  logic       clr,
  input  logic       coin_ack,
  output logic       coin_req,
  output logic [1:0] coin_sel,
  output logic       busy,
  output logic       done,
  output logic       short,
  output logic       fault,
  output logic [3:0] remaining,
  output logic [2:0] empty
);

  localparam int unsigned TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

  state_t        state;
  logic [3:0]    n5, n2, n1;
  logic [TW-1:0] ack_cnt;
  logic [1:0]    pick_sel;
  logic          pick_valid;

  coin_pick u_pick (
    .remaining (remaining),
    .n5        (n5),
    .n2        (n2),
    .n1        (n1),
    .sel       (pick_sel),
    .valid     (pick_valid)
  );

  assign empty = {n5 == '0, n2 == '0, n1 == '0};

  always_ff @(posedge clk_1ms or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      coin_req  <= 1'b0;
      coin_sel  <= SEL_1;
      busy      <= 1'b0;
      done      <= 1'b0;
      short     <= 1'b0;
      fault     <= 1'b0;
      remaining <= '0;
      ack_cnt   <= '0;
      n5        <= 4'(N5_INIT);
      n2        <= 4'(N2_INIT);
      n1        <= 4'(N1_INIT);
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_SELECT;
            remaining <= amount;
            busy      <= 1'b1;
          end
        end

        S_SELECT: begin
          if (remaining == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else if (pick_valid) begin
            state    <= S_REQ;
            coin_sel <= pick_sel;
            coin_req <= 1'b1;
            ack_cnt  <= '0;
          end else begin
            state <= S_SHORT;
            short <= 1'b1;
          end
        end

        // The timeout counter counts cycles spent in REQ without an ack;
        // the final unacknowledged cycle moves straight to FAULT.
        S_REQ: begin
          if (coin_ack) begin
            state     <= S_REL;
            coin_req  <= 1'b0;
            remaining <= remaining - coin_value(coin_sel);
            case (coin_sel)
              SEL_5:   if (n5 != '0) n5 <= n5 - 4'd1;
              SEL_2:   if (n2 != '0) n2 <= n2 - 4'd1;
              SEL_1:   if (n1 != '0) n1 <= n1 - 4'd1;
              default: ;
            endcase
          end else if (ack_cnt == TO_LAST) begin
            state    <= S_FAULT;
            coin_req <= 1'b0;
            fault    <= 1'b1;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end

        S_REL: begin
          if (!coin_ack) state <= S_SELECT;
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        S_SHORT: begin
          if (clr) begin
            state     <= S_IDLE;
            short     <= 1'b0;
            busy      <= 1'b0;
            remaining <= '0;
          end
        end

        S_FAULT: begin
          if (clr) begin
            state <= S_IDLE;
            fault <= 1'b0;
            busy  <= 1'b0;
          end
        end

        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          coin_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
